// File: rtl/pll_reset_seq_pkg.sv
// pll_reset_sequencer shared types: FSM state enum and counter sizing helper.
// Used by pll_reset_sequencer (PLL_RESET_SEQUENCER_AUTORECOVER_EN selects loss policy).
package pll_reset_seq_pkg;

  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAULT     = 3'd5
  } state_t;

  function automatic int cnt_width(
    input int a,
    input int b,
    input int c,
    input int d
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (m < 1) m = 1;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic 2-flop synchronizer with synchronous active-high reset to RST_VAL.
// Ports: clk, rst, d (async input), q (synchronized output, 2-cycle lag).
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL supervisor: pulses pll_rst, qualifies lock, then releases rst_out_0/rst_out_1.
// Loss of lock -> FAULT, or full re-sequence if PLL_RESET_SEQUENCER_AUTORECOVER_EN.
module pll_reset_sequencer
  import pll_reset_seq_pkg::*;
#(
  parameter int PLL_RST_CYCLES     = 16,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int LOCK_TIMEOUT       = 50000,
  parameter int RELEASE_GAP        = 64,
  parameter int CNT_W              = 8
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             locked,
  output logic             pll_rst,
  output logic             rst_out_0,
  output logic             rst_out_1,
  output logic             ready,
  output logic             fault,
  output logic [CNT_W-1:0] retry_cnt,
  output logic [CNT_W-1:0] loss_cnt
);

  localparam int TW = cnt_width(
    PLL_RST_CYCLES, LOCK_STABLE_CYCLES,
    LOCK_TIMEOUT, RELEASE_GAP
  );

  localparam logic [TW-1:0] T_RST =
    TW'(PLL_RST_CYCLES - 1);
  localparam logic [TW-1:0] T_TO =
    TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] T_STB =
    TW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TW-1:0] T_GAP =
    TW'(RELEASE_GAP - 1);

  state_t        state;
  state_t        state_n;
  logic [TW-1:0] cnt;
  logic [TW-1:0] cnt_n;
  logic          locked_s;
  logic          retry_inc;
  logic          loss_inc;

  sync_2ff #(
    .RST_VAL(1'b0)
  ) u_lock_sync (
    .clk(refclk),
    .rst(rst),
    .d  (locked),
    .q  (locked_s)
  );

  always_comb begin
    state_n   = state;
    cnt_n     = cnt + 1'b1;
    retry_inc = 1'b0;
    loss_inc  = 1'b0;
    unique case (state)
      ST_RESET_PLL: begin
        if (cnt == T_RST) begin
          state_n = ST_WAIT_LOCK;
          cnt_n   = '0;
        end
      end
      ST_WAIT_LOCK: begin
        if (locked_s) begin
          state_n = ST_STABLE;
          cnt_n   = '0;
        end else if (cnt == T_TO) begin
          state_n   = ST_RESET_PLL;
          cnt_n     = '0;
          retry_inc = 1'b1;
        end
      end
      ST_STABLE: begin
        if (!locked_s) begin
          state_n = ST_WAIT_LOCK;
          cnt_n   = '0;
        end else if (cnt == T_STB) begin
          state_n = ST_RELEASE;
          cnt_n   = '0;
        end
      end
      ST_RELEASE: begin
        if (!locked_s) begin
          loss_inc = 1'b1;
          cnt_n    = '0;
`ifdef PLL_RESET_SEQUENCER_AUTORECOVER_EN
          state_n  = ST_RESET_PLL;
`else
          state_n  = ST_FAULT;
`endif
        end else if (cnt == T_GAP) begin
          state_n = ST_RUN;
          cnt_n   = '0;
        end
      end
      ST_RUN: begin
        cnt_n = '0;
        if (!locked_s) begin
          loss_inc = 1'b1;
`ifdef PLL_RESET_SEQUENCER_AUTORECOVER_EN
          state_n  = ST_RESET_PLL;
`else
          state_n  = ST_FAULT;
`endif
        end
      end
      ST_FAULT: begin
        cnt_n = '0;
      end
      default: begin
        state_n = ST_RESET_PLL;
        cnt_n   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they
  // line up with the state register cycle for cycle.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state     <= ST_RESET_PLL;
      cnt       <= '0;
      pll_rst   <= 1'b1;
      rst_out_0 <= 1'b1;
      rst_out_1 <= 1'b1;
      ready     <= 1'b0;
      fault     <= 1'b0;
      retry_cnt <= '0;
      loss_cnt  <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      pll_rst   <= (state_n == ST_RESET_PLL);
      rst_out_0 <= !((state_n == ST_RELEASE) ||
                     (state_n == ST_RUN));
      rst_out_1 <= (state_n != ST_RUN);
      ready     <= (state_n == ST_RUN);
      fault     <= fault || (state_n == ST_FAULT);
      if (retry_inc && (retry_cnt != '1))
        retry_cnt <= retry_cnt + 1'b1;
      if (loss_inc && (loss_cnt != '1))
        loss_cnt <= loss_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer against a phase/duration model.
// Honours PLL_RESET_SEQUENCER_AUTORECOVER_EN for loss-of-lock expectations.
module tb_pll_reset_sequencer;

  localparam int PRC = 4;
  localparam int LSC = 8;
  localparam int LTO = 32;
  localparam int GAP = 3;
  localparam int CW  = 8;
  localparam int SATV = (1 << CW) - 1;

  logic          refclk = 1'b0;
  logic          rst    = 1'b1;
  logic          locked = 1'b0;
  logic          pll_rst;
  logic          rst_out_0;
  logic          rst_out_1;
  logic          ready;
  logic          fault;
  logic [CW-1:0] retry_cnt;
  logic [CW-1:0] loss_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 refclk = ~refclk;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES    (PRC),
    .LOCK_STABLE_CYCLES(LSC),
    .LOCK_TIMEOUT      (LTO),
    .RELEASE_GAP       (GAP),
    .CNT_W             (CW)
  ) dut (
    .refclk   (refclk),
    .rst      (rst),
    .locked   (locked),
    .pll_rst  (pll_rst),
    .rst_out_0(rst_out_0),
    .rst_out_1(rst_out_1),
    .ready    (ready),
    .fault    (fault),
    .retry_cnt(retry_cnt),
    .loss_cnt (loss_cnt)
  );

  // Model: current phase plus how many cycles it has lasted.
  typedef enum int {
    PH_PLL, PH_WAIT, PH_STB, PH_REL, PH_RUN, PH_FLT
  } ph_t;

  ph_t ph = PH_PLL;
  int  dur = 0;
  bit  m_fault = 0;
  int  m_retry = 0;
  int  m_loss  = 0;
  bit  s1 = 0;
  bit  s2 = 0;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= SATV) ? SATV : v + 1;
  endfunction

  task automatic enter(input ph_t p);
    ph  = p;
    dur = 0;
  endtask

  task automatic model_edge(input bit r, input bit lk);
    bit ls;
    ls = s2;
    if (r) begin
      enter(PH_PLL);
      m_fault = 0;
      m_retry = 0;
      m_loss  = 0;
      s1 = 0;
      s2 = 0;
      return;
    end
    s2 = s1;
    s1 = lk;
    dur++;
    if ((ph == PH_REL || ph == PH_RUN) && !ls) begin
      m_loss = sat(m_loss);
`ifdef PLL_RESET_SEQUENCER_AUTORECOVER_EN
      enter(PH_PLL);
`else
      enter(PH_FLT);
      m_fault = 1;
`endif
    end else begin
      case (ph)
        PH_PLL:  if (dur == PRC) enter(PH_WAIT);
        PH_WAIT: begin
          if (ls) enter(PH_STB);
          else if (dur == LTO) begin
            enter(PH_PLL);
            m_retry = sat(m_retry);
          end
        end
        PH_STB: begin
          if (!ls) enter(PH_WAIT);
          else if (dur == LSC) enter(PH_REL);
        end
        PH_REL:  if (dur == GAP) enter(PH_RUN);
        default: ;
      endcase
    end
  endtask

  task automatic check_outs();
    bit up;
    up = (ph == PH_REL) || (ph == PH_RUN);
    chk("pll_rst",   pll_rst,   ph == PH_PLL);
    chk("rst_out_0", rst_out_0, !up);
    chk("rst_out_1", rst_out_1, ph != PH_RUN);
    chk("ready",     ready,     ph == PH_RUN);
    chk("fault",     fault,     m_fault);
    chk("retry_cnt", retry_cnt, m_retry);
    chk("loss_cnt",  loss_cnt,  m_loss);
  endtask

  task automatic step();
    @(posedge refclk);
    model_edge(rst, locked);
    #1;
    check_outs();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic wait_ph(input ph_t p, input int d,
                         input int lim);
    int k;
    k = 0;
    while (!(ph == p && dur == d) && k < lim) begin
      step();
      k++;
    end
    chk("wait_bound", (ph == p && dur == d), 1);
  endtask

  initial begin
    int t0;
    int t1;
    int hold;

    // Reset pulse and 4-cycle pll_rst after release.
    rst = 1; locked = 0;
    run(3);
    rst = 0;
    run(PRC + 5);

    // Clean bring-up; measure the release gap.
    locked = 1;
    t0 = -1;
    t1 = -1;
    for (int k = 0; k < 60; k++) begin
      step();
      if (t0 < 0 && rst_out_0 === 1'b0) t0 = k;
      if (t1 < 0 && rst_out_1 === 1'b0) t1 = k;
    end
    chk("release_gap", t1 - t0, GAP);
    chk("ready_up", ready, 1);

    // Loss of lock while running.
    locked = 0;
    run(2);
    locked = 1;
    run(30);
    chk("loss_one", loss_cnt, 1);
`ifdef PLL_RESET_SEQUENCER_AUTORECOVER_EN
    chk("recovered", ready, 1);
    chk("no_fault", fault, 0);
`else
    chk("fault_sticky", fault, 1);
    chk("pll_rst_low", pll_rst, 0);
`endif

    // Timeout retries until the counter saturates.
    rst = 1; locked = 0;
    run(1);
    rst = 0;
    run(PRC + LTO);
    chk("retry_first", retry_cnt, 1);
    run(300 * (PRC + LTO));
    chk("retry_sat", retry_cnt, SATV);

    // One-cycle glitch during STABLE.
    rst = 1;
    run(2);
    rst = 0;
    run(PRC + 2);
    locked = 1;
    wait_ph(PH_STB, 4, 100);
    locked = 0;
    step();
    locked = 1;
    run(40);
    chk("glitch_retry", retry_cnt, 0);
    chk("glitch_ready", ready, 1);

    // rst between the two domain releases.
    rst = 1;
    run(1);
    rst = 0;
    wait_ph(PH_REL, 1, 100);
    chk("mid_rel_r0", rst_out_0, 0);
    rst = 1;
    step();
    chk("mid_rel_pll", pll_rst, 1);
    chk("mid_rel_r0b", rst_out_0, 1);
    chk("mid_rel_r1", rst_out_1, 1);
    chk("mid_rel_loss", loss_cnt, 0);
    rst = 0;

    // Random lock behaviour with sporadic rst.
    hold = 0;
    for (int k = 0; k < 4000; k++) begin
      if (hold == 0) begin
        locked = ($urandom_range(0, 3) != 0);
        hold = $urandom_range(1, 50);
      end
      hold--;
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 0;
    run(2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Supervises the streaming PLL (50 MHz ref → 130 MHz / 65 MHz outputs) and sequences resets for its two output-clock domains.
- Drives the PLL's rst input and watches its asynchronous locked output.
- Releases the outclk_0 reset first, then the outclk_1 reset, only after lock has been stable for a set time.
- Retries the PLL on lock timeout and handles loss of lock.
- Runs entirely on the free-running reference clock, so it works before lock.

Parameters:
- PLL_RST_CYCLES, 16: width of the pll_rst pulse, in refclk cycles.
- LOCK_STABLE_CYCLES, 1024: consecutive synchronized-lock cycles required before releasing resets.
- LOCK_TIMEOUT, 50000: cycles in WAIT_LOCK before the PLL is re-reset (1 ms at 50 MHz).
- RELEASE_GAP, 64: cycles between deasserting rst_out_0 and deasserting rst_out_1.
- CNT_W, 8: width of the saturating retry and loss counters.

Ports:
- refclk  in  1  50 MHz reference clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- locked  in  1  PLL lock, asynchronous to refclk.
- pll_rst  out  1  reset to the PLL, active-high.
- rst_out_0  out  1  reset for the outclk_0 domain, active-high; the consumer synchronizes deassertion.
- rst_out_1  out  1  reset for the outclk_1 domain, active-high.
- ready  out  1  both domain resets released and lock valid.
- fault  out  1  lock lost while running; sticky (only when the macro is undefined).
- retry_cnt  out  CNT_W  lock-timeout retries, saturating.
- loss_cnt  out  CNT_W  lock losses seen in RELEASE/RUN, saturating.

Behaviour:
- Interface: one clock (refclk); reset (rst) is synchronous and active-high.
- locked passes through a 2-flop synchronizer to give locked_s, so it lags locked by 2 cycles. All outputs are registered.
- Reset values while rst=1:
  - State RESET_PLL, all counters 0.
  - pll_rst=1, rst_out_0=1, rst_out_1=1.
  - ready=0, fault=0, retry_cnt=0, loss_cnt=0.
  - The synchronizer flops clear to 0.
- States: RESET_PLL, WAIT_LOCK, STABLE, RELEASE, RUN, FAULT.
- RESET_PLL:
  - pll_rst=1 for exactly PLL_RST_CYCLES cycles counted from entry, including the first cycle after rst falls.
  - Then go to WAIT_LOCK; pll_rst=0 from that cycle.
- WAIT_LOCK:
  - A timeout counter starts at 0 on entry.
  - locked_s=1 → STABLE.
  - Counter reaches LOCK_TIMEOUT-1 with locked_s=0 → RESET_PLL, retry_cnt+1 (saturating at all-ones).
- STABLE:
  - locked_s must stay 1 for LOCK_STABLE_CYCLES consecutive cycles, counted from entry.
  - Any 0 → WAIT_LOCK with the timeout counter restarted; no retry increment.
  - Count complete → RELEASE.
- RELEASE:
  - rst_out_0=0 from the entry cycle.
  - rst_out_1 falls exactly RELEASE_GAP cycles after rst_out_0 falls.
  - Go to RUN on the same cycle, with ready=1.
- RUN: steady state, with both domain resets low and ready=1.
- Loss of lock (locked_s=0 in RELEASE or RUN):
  - On the next cycle: rst_out_0=1, rst_out_1=1, ready=0, loss_cnt+1 (saturating).
  - The state transition depends on the optional feature.
- FAULT:
  - pll_rst=0, both domain resets held at 1, ready=0, fault=1.
  - Exit only via rst.
- Domain resets are never deasserted outside RELEASE/RUN. pll_rst is only ever 1 in RESET_PLL.
- rst mid-operation, in any state: rst wins and restores all reset values on the next edge.

Optional Feature:
- Macro: PLL_RESET_SEQUENCER_AUTORECOVER_EN.
- Defined: a loss of lock goes to RESET_PLL, runs the full sequence again, and fault stays 0.
- Undefined: a loss of lock goes to FAULT and latches fault=1 until rst.

Decomposition:
- Shared package pll_reset_seq_pkg holds:
  - the state enum (3-bit);
  - a counter-width helper based on $clog2 of the largest timing parameter.
- One sub-module, sync_2ff: a generic 2-flop synchronizer with a reset value, reused for the locked input.

Test Plan:
Simulation parameters: PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT=32, RELEASE_GAP=3, CNT_W=8.
- Reset and pulse: rst high 3 cycles, locked=0 → pll_rst high for exactly 4 cycles after rst falls; rst_out_0/1=1 and ready=0 throughout.
- Clean bring-up: locked rises 5 cycles into WAIT_LOCK and stays high.
  - STABLE entered 2 cycles after locked rises (synchronizer lag); STABLE lasts 8 cycles.
  - rst_out_0 falls next; rst_out_1 and ready follow 3 cycles later.
- Timeout retry: locked held 0 → after 32 WAIT_LOCK cycles, pll_rst reasserts for 4 cycles and retry_cnt=1; after 300 retries, retry_cnt=255 (saturated).
- Glitch during STABLE: locked drops 1 cycle at STABLE cycle 5 → back to WAIT_LOCK, no reset release, retry_cnt unchanged; full 8-cycle stability required afterwards.
- Loss in RUN:
  - Macro defined: both rst_out=1 and ready=0 within 3 cycles of locked falling; loss_cnt=1; full sequence reruns.
  - Macro undefined: fault=1 is sticky and pll_rst stays 0 until rst.
- rst asserted mid-RELEASE (after rst_out_0 falls, before rst_out_1) → next edge restores all reset values; counters return to 0.
